// File: rtl/kgv_stage.sv
// kgv_stage: least common multiple of two operands using a GCD supplied by an external unit.
// Latency: 33 clk edges for WIDTH=16 (2*WIDTH+1) from the sampled ggt_valid_i rising edge to the kgv_valid_o
//          cycle; 1 edge on the zero-operand / zero-GCD shortcut.
// Backpressure: none; start_i is ignored while busy, except in the DONE cycle.
//
// Ports:
//   clk, rst_i          clock and asynchronous active-low reset
//   start_i             job start, latches Zahl1_i / Zahl2_i (shared with the GCD unit's start)
//   ggt_valid_i, ggt_i  GCD result handshake; only a rising edge of ggt_valid_i is used
//   busy_o              high from the accepted start through the DONE cycle
//   kgv_valid_o         single-cycle result strobe
//   kgv_o, err_o        result and error flag, held until the next accepted start
module kgv_stage #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     Zahl1_i,
    input  logic [WIDTH-1:0]     Zahl2_i,
    input  logic                 ggt_valid_i,
    input  logic [WIDTH-1:0]     ggt_i,
    output logic                 busy_o,
    output logic                 kgv_valid_o,
    output logic [2*WIDTH-1:0]   kgv_o,
    output logic                 err_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_GGT = 3'd1;
    localparam logic [2:0] S_DIV      = 3'd2;
    localparam logic [2:0] S_MUL      = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   g_q, g_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] kgv_q, kgv_d;
    logic               err_q, err_d;
    logic               ggt_vld_q;

    logic               ggt_rise;
    logic               last_step;
    logic [WIDTH:0]     r_sh;
    logic [WIDTH:0]     r_diff;
    logic               r_ge;
    logic [WIDTH-1:0]   q_sh;
    logic [2*WIDTH-1:0] acc_sum;

    assign ggt_rise  = ggt_valid_i & ~ggt_vld_q;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // Division step. The stored remainder is always < G, so the shifted
    // partial remainder (WIDTH+1 bits) is at most 2G-1. Hence r_sh-G is
    // either in [0, G-1] (top bit clear) or negative (wraps, top bit set):
    // the top bit of the difference is exactly the "r_sh < G" borrow.
    assign r_sh   = {r_q, q_q[WIDTH-1]};
    assign r_diff = r_sh - {1'b0, g_q};
    assign r_ge   = ~r_diff[WIDTH];
    assign q_sh   = q_q << 1;

    // Multiply step: add the shifted multiplicand when the quotient LSB is set.
    assign acc_sum = acc_q + (q_q[0] ? mcand_q : '0);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        g_d     = g_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        kgv_d   = kgv_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    a_d     = Zahl1_i;
                    b_d     = Zahl2_i;
                    kgv_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT_GGT;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end

            S_WAIT_GGT: begin
                if (ggt_rise) begin
                    g_d = ggt_i;
                    if (a_q == '0 || b_q == '0) begin
                        kgv_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else if (ggt_i == '0) begin
                        kgv_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        r_d     = '0;
                        q_d     = a_q;
                        cnt_d   = '0;
                        state_d = S_DIV;
                    end
                end
            end

            S_DIV: begin
                if (r_ge) begin
                    r_d = r_diff[WIDTH-1:0];
                    q_d = q_sh | WIDTH'(1);
                end else begin
                    r_d = r_sh[WIDTH-1:0];
                    q_d = q_sh;
                end
                if (last_step) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    mcand_d = {{WIDTH{1'b0}}, b_q};
                    state_d = S_MUL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_MUL: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 1;
                q_d     = q_q >> 1;
                if (last_step) begin
                    kgv_d   = acc_sum;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            g_q       <= '0;
            r_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            kgv_q     <= '0;
            err_q     <= 1'b0;
            ggt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            g_q       <= g_d;
            r_q       <= r_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            kgv_q     <= kgv_d;
            err_q     <= err_d;
            // Edge-detect history runs in every state so a level already
            // high at start acceptance is never seen as a new result.
            ggt_vld_q <= ggt_valid_i;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign kgv_valid_o = (state_q == S_DONE);
    assign kgv_o       = kgv_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_kgv_stage.sv
module tb_kgv_stage;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_i;
    logic           start_i;
    logic [W-1:0]   Zahl1_i, Zahl2_i;
    logic           ggt_valid_i;
    logic [W-1:0]   ggt_i;
    logic           busy_o, kgv_valid_o, err_o;
    logic [2*W-1:0] kgv_o;

    kgv_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst_i(rst_i), .start_i(start_i),
        .Zahl1_i(Zahl1_i), .Zahl2_i(Zahl2_i),
        .ggt_valid_i(ggt_valid_i), .ggt_i(ggt_i),
        .busy_o(busy_o), .kgv_valid_o(kgv_valid_o),
        .kgv_o(kgv_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] kgv;
        logic           err;
        int             cyc;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every result strobe must match the oldest outstanding job.
    always @(negedge clk) begin
        if (kgv_valid_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got kgv_valid_o=1 kgv_o=%0d, expected no result (t=%0t)", kgv_o, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("kgv_o", longint'(kgv_o), longint'(e.kgv));
                check("err_o", longint'(err_o), longint'(e.err));
                check("latency_edge", longint'(cyc), longint'(e.cyc));
            end
        end
    end

    function automatic logic [W-1:0] gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Reference: lcm = (a / g) * b, with zero-operand and zero-GCD shortcuts.
    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] g,
                           input bit held, input bit inject);
        exp_t e;
        bit   shortcut;
        int   n;
        shortcut = (a == 0) || (b == 0) || (g == 0);
        if (a == 0 || b == 0) begin
            e.kgv = '0; e.err = 1'b0;
        end else if (g == 0) begin
            e.kgv = '0; e.err = 1'b1;
        end else begin
            longint unsigned p;
            p = longint'(a / g) * longint'(b);
            e.kgv = p[2*W-1:0];
            e.err = 1'b0;
        end

        @(posedge clk); #1;
        if (held) begin ggt_i = g; ggt_valid_i = 1'b1; end
        else ggt_valid_i = 1'b0;
        start_i = 1'b1; Zahl1_i = a; Zahl2_i = b;
        @(posedge clk); #1;
        start_i = 1'b0; Zahl1_i = W'($urandom); Zahl2_i = W'($urandom);
        if (held) begin
            repeat (4) begin @(posedge clk); #1; end
            check("busy_while_held", longint'(busy_o), 1);
            ggt_valid_i = 1'b0;
            @(posedge clk); #1;
        end
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        ggt_i = g;
        ggt_valid_i = 1'b1;
        e.cyc = cyc + 1 + (shortcut ? 0 : 2 * W);
        sb.push_back(e);
        if (inject) begin
            repeat (6) begin @(posedge clk); #1; end
            start_i = 1'b1; Zahl1_i = 3; Zahl2_i = 4;
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no kgv_valid_o within 60 cycles, expected result kgv=%0d", e.kgv);
            sb.delete();
        end else begin
            check("busy_after_done", longint'(busy_o), 0);
        end
        ggt_valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; Zahl1_i = '0; Zahl2_i = '0;
        ggt_valid_i = 1'b0; ggt_i = '0;
        #12;
        check("rst_busy", longint'(busy_o), 0);
        check("rst_valid", longint'(kgv_valid_o), 0);
        check("rst_kgv", longint'(kgv_o), 0);
        check("rst_err", longint'(err_o), 0);
        #11 rst_i = 1'b1;

        run_job(12, 18, 6, 0, 0);
        run_job(16'hFFFF, 16'hFFFE, 1, 0, 0);
        run_job(0, 7, 7, 0, 0);
        run_job(5, 10, 0, 0, 0);
        run_job(0, 0, 0, 0, 0);
        run_job(9, 6, 3, 1, 0);
        run_job(12, 18, 6, 0, 1);

        // Asynchronous reset in the middle of a division.
        @(posedge clk); #1;
        start_i = 1'b1; Zahl1_i = 12; Zahl2_i = 18;
        @(posedge clk); #1;
        start_i = 1'b0;
        ggt_i = 6; ggt_valid_i = 1'b1;
        repeat (5) @(posedge clk);
        #3 rst_i = 1'b0;
        #1;
        check("abort_busy", longint'(busy_o), 0);
        check("abort_valid", longint'(kgv_valid_o), 0);
        check("abort_kgv", longint'(kgv_o), 0);
        check("abort_err", longint'(err_o), 0);
        ggt_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_i = 1'b1;
        repeat (40) @(posedge clk);
        run_job(4, 6, 2, 0, 0);

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a, b, g;
            int sel;
            a = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 200)) : W'($urandom);
            b = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 200)) : W'($urandom);
            if ($urandom_range(0, 9) == 0) a = '0;
            sel = $urandom_range(0, 9);
            if (sel < 7)       g = gcd(a, b);
            else if (sel == 7) g = '0;
            else               g = W'($urandom_range(1, 65535));
            run_job(a, b, g, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion within 2 ms");
        $fatal(1);
    end
endmodule
